// File: rtl/main_port_arbiter.sv
// Two-requester round-robin arbiter onto a single main memory port.
// One access every two cycles: a grant decision in IDLE, then one ISSUE cycle.
module main_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          Wr0,
    input  logic          Wr1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData0,
    input  logic [DW-1:0] WData1,
    output logic          Gnt0,
    output logic          Gnt1,
    output logic          RValid0,
    output logic          RValid1,
    output logic [DW-1:0] RData0,
    output logic [DW-1:0] RData1,
    output logic          RD,
    output logic          WR,
    output logic [AW-1:0] Addr,
    output logic [DW-1:0] DataIn,
    input  logic [DW-1:0] DataOut,
    output logic [15:0]   AccessCount
);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t      state;
    logic        last;
    logic        win;
    logic        pick;
    logic [15:0] access_count;

    // On a tie the requester not granted last wins.
    assign pick        = (Req0 && Req1) ? ~last : Req1;
    assign AccessCount = access_count;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            win          <= 1'b0;
            RD           <= 1'b0;
            WR           <= 1'b0;
            Gnt0         <= 1'b0;
            Gnt1         <= 1'b0;
            RValid0      <= 1'b0;
            RValid1      <= 1'b0;
            Addr         <= '0;
            DataIn       <= '0;
            RData0       <= '0;
            RData1       <= '0;
            access_count <= '0;
        end else begin
            RValid0 <= 1'b0;
            RValid1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Req0 || Req1) begin
                        state  <= ISSUE;
                        win    <= pick;
                        WR     <= pick ? Wr1 : Wr0;
                        RD     <= pick ? ~Wr1 : ~Wr0;
                        Addr   <= pick ? Addr1 : Addr0;
                        DataIn <= pick ? WData1 : WData0;
                        Gnt0   <= ~pick;
                        Gnt1   <= pick;
                    end
                end
                ISSUE: begin
                    state <= IDLE;
                    RD    <= 1'b0;
                    WR    <= 1'b0;
                    Gnt0  <= 1'b0;
                    Gnt1  <= 1'b0;
                    last  <= win;
                    if (access_count != 16'hFFFF) begin
                        access_count <= access_count + 16'd1;
                    end
                    // Read data is only valid while RD is high.
                    if (RD) begin
                        if (win) begin
                            RData1  <= DataOut;
                            RValid1 <= 1'b1;
                        end else begin
                            RData0  <= DataOut;
                            RValid0 <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_port_arbiter.sv
// Scoreboard bench for main_port_arbiter: a transaction-level model predicts
// grant order, port contents and read data; a negedge monitor compares.
module tb_main_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Req0 = 1'b0, Req1 = 1'b0;
    logic          Wr0 = 1'b0, Wr1 = 1'b0;
    logic [AW-1:0] Addr0 = '0, Addr1 = '0;
    logic [DW-1:0] WData0 = '0, WData1 = '0;
    logic          Gnt0, Gnt1, RValid0, RValid1;
    logic [DW-1:0] RData0, RData1;
    logic          RD, WR;
    logic [AW-1:0] Addr;
    logic [DW-1:0] DataIn;
    logic [DW-1:0] DataOut;
    logic [15:0]   AccessCount;

    main_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
        .RData0(RData0), .RData1(RData1), .RD(RD), .WR(WR),
        .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut),
        .AccessCount(AccessCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } tx_t;

    typedef struct packed {
        logic          id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } rd_t;

    tx_t  txq0[$];
    tx_t  txq1[$];
    acc_t exp_acc[$];
    rd_t  exp_rd[$];

    logic [DW-1:0] mem [16] = '{default: '0};
    logic [DW-1:0] ref_mem [16] = '{default: '0};

    int n_cmp = 0;
    int n_err = 0;

    logic        m_busy = 1'b0;
    logic        m_last = 1'b1;
    logic        m_cur = 1'b0;
    logic [15:0] m_cnt = '0;

    // Main memory behind the port.
    assign DataOut = mem[Addr[3:0]];
    always @(posedge Clk) if (WR) mem[Addr[3:0]] <= DataIn;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: serialised accesses, round-robin on ties.
    always @(posedge Clk) begin : model
        acc_t a;
        rd_t  r;
        if (!Reset) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_cnt  = '0;
            exp_acc.delete();
            exp_rd.delete();
        end else if (m_busy) begin
            m_busy = 1'b0;
            m_last = m_cur;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (Req0 || Req1) begin
            m_cur   = (Req0 && Req1) ? !m_last : Req1;
            a.id    = m_cur;
            a.wr    = m_cur ? Wr1 : Wr0;
            a.addr  = m_cur ? Addr1 : Addr0;
            a.wdata = m_cur ? WData1 : WData0;
            exp_acc.push_back(a);
            if (a.wr) begin
                ref_mem[a.addr[3:0]] = a.wdata;
            end else begin
                r.id   = m_cur;
                r.data = ref_mem[a.addr[3:0]];
                exp_rd.push_back(r);
            end
            m_busy = 1'b1;
        end
    end

    always @(negedge Clk) begin : monitor
        acc_t a;
        rd_t  r;
        check("rd_wr_excl", RD && WR, 0);
        check("gnt_excl", Gnt0 && Gnt1, 0);
        check("rvalid_excl", RValid0 && RValid1, 0);
        check("access_count", AccessCount, m_cnt);
        if (Gnt0 || Gnt1) begin
            if (exp_acc.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: got gnt0=%0b gnt1=%0b, want none",
                         Gnt0, Gnt1);
            end else begin
                a = exp_acc.pop_front();
                check("gnt_id", Gnt1, a.id);
                check("wr", WR, a.wr);
                check("rd", RD, !a.wr);
                check("addr", Addr, a.addr);
                if (a.wr) check("datain", DataIn, a.wdata);
            end
        end else begin
            check("idle_rd_wr", RD || WR, 0);
        end
        if (RValid0 || RValid1) begin
            if (exp_rd.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rvalid: got rv0=%0b rv1=%0b, want none",
                         RValid0, RValid1);
            end else begin
                r = exp_rd.pop_front();
                check("rvalid_id", RValid1, r.id);
                check("rdata", r.id ? RData1 : RData0, r.data);
            end
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
        if (Gnt0 && txq0.size() > 0) void'(txq0.pop_front());
        if (Gnt1 && txq1.size() > 0) void'(txq1.pop_front());
        Req0 = (txq0.size() != 0);
        Req1 = (txq1.size() != 0);
        if (Req0) {Wr0, Addr0, WData0} = txq0[0];
        else {Wr0, Addr0, WData0} = {1'($urandom), 16'($urandom), $urandom};
        if (Req1) {Wr1, Addr1, WData1} = txq1[0];
        else {Wr1, Addr1, WData1} = {1'($urandom), 16'($urandom), $urandom};
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((txq0.size() != 0 || txq1.size() != 0 || exp_acc.size() != 0 ||
                exp_rd.size() != 0 || m_busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d cycles, want < %0d", n, budget);
        end
        step();
        step();
    endtask

    function automatic tx_t mk(input logic wr, input int addr, input logic [DW-1:0] d);
        tx_t t;
        t.wr    = wr;
        t.addr  = AW'(addr);
        t.wdata = d;
        return t;
    endfunction

    initial begin
        int n;
        Reset = 1'b0;
        step();
        step();
        check("rst_rd", RD, 0);
        check("rst_wr", WR, 0);
        check("rst_gnt", {Gnt1, Gnt0}, 0);
        check("rst_rvalid", {RValid1, RValid0}, 0);
        check("rst_addr", Addr, 0);
        check("rst_datain", DataIn, 0);
        check("rst_rdata0", RData0, 0);
        check("rst_rdata1", RData1, 0);
        check("rst_count", AccessCount, 0);
        Reset = 1'b1;
        step();

        txq0.push_back(mk(1'b1, 5, 32'd7));
        drain(50);
        check("count_after_first", AccessCount, 16'd1);
        txq0.push_back(mk(1'b1, 9, 32'h1234));
        drain(50);
        txq1.push_back(mk(1'b0, 9, 32'h0));
        drain(50);
        check("rdata1_hold", RData1, 32'h1234);
        check("rdata0_untouched", RData0, 32'h0);

        for (int i = 0; i < 4; i++) begin
            txq0.push_back(mk(1'b1, i, 32'hA000 + i));
            txq1.push_back(mk(1'b0, i, 32'h0));
        end
        drain(100);

        // Abort a read by resetting during its ISSUE cycle.
        txq0.push_back(mk(1'b0, 3, 32'h0));
        n = 0;
        do begin
            step();
            n++;
        end while (!Gnt0 && n < 20);
        check("abort_saw_gnt0", Gnt0, 1);
        Reset = 1'b0;
        step();
        check("abort_rd", RD, 0);
        check("abort_wr", WR, 0);
        check("abort_rvalid", {RValid1, RValid0}, 0);
        check("abort_count", AccessCount, 0);
        Reset = 1'b1;
        step();
        check("abort_no_late_rvalid", {RValid1, RValid0}, 0);

        for (int c = 0; c < 3000; c++) begin
            if (txq0.size() == 0 && $urandom_range(0, 2) == 0)
                txq0.push_back(mk(1'($urandom), int'($urandom_range(0, 15)), $urandom));
            if (txq1.size() == 0 && $urandom_range(0, 2) == 0)
                txq1.push_back(mk(1'($urandom), int'($urandom_range(0, 15)), $urandom));
            step();
        end
        drain(100);

        force dut.access_count = 16'hFFFD;
        m_cnt = 16'hFFFD;
        step();
        release dut.access_count;
        check("count_preset", AccessCount, 16'hFFFD);
        for (int i = 0; i < 3; i++) txq0.push_back(mk(1'b1, i, 32'h5A00 + i));
        txq1.push_back(mk(1'b0, 1, 32'h0));
        drain(100);
        check("count_saturated", AccessCount, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
